ball_motion: RTL and testbench



---
 rtl/ball_motion.sv | 191 +++++++++++++++++++
 tb/tb_ball_motion.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ball_motion.sv
// Breakout ball physics: steps the ball on a divided tick, reflects it off
// the walls, the paddle and a single row of bricks, and tracks live bricks.
module ball_motion #(
    parameter int H_RES     = 640,
    parameter int V_RES     = 480,
    parameter int BALL_SIZE = 8,
    parameter int PADDLE_Y  = 440,
    parameter int PADDLE_W  = 64,
    parameter int N_BLOCKS  = 10,
    parameter int BLOCK_W   = 64,
    parameter int BLOCK_Y   = 32,
    parameter int BLOCK_H   = 16,
    parameter int STEP_DIV  = 416667
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [9:0]          paddle_x,
    output logic [9:0]          ball_x,
    output logic [9:0]          ball_y,
    output logic [N_BLOCKS-1:0] blocks_alive,
    output logic                hit_block,
    output logic                endgame_ball,
    output logic                all_clear,
    output logic                moving
);

    localparam logic [9:0]  X_MAX     = 10'(H_RES - BALL_SIZE);
    localparam logic [9:0]  Y_MAX     = 10'(V_RES - BALL_SIZE);
    localparam logic [9:0]  P_MAX     = 10'(H_RES - PADDLE_W);
    localparam logic [9:0]  SERVE_Y   = 10'(PADDLE_Y - BALL_SIZE);
    localparam logic [10:0] BRICK_BOT = 11'(BLOCK_Y + BLOCK_H);
    localparam logic [10:0] BRICK_TOP = 11'(BLOCK_Y);
    localparam logic [10:0] PAD_TOP   = 11'(PADDLE_Y);
    localparam int          IDX_SH    = $clog2(BLOCK_W);
    localparam int          CW        = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STEP_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, LOST, WIN} state_t;

    state_t              state_q, state_d;
    logic [9:0]          x_q, x_d;
    logic [9:0]          y_q, y_d;
    logic                dx_neg_q, dx_neg_d;   // 1: moving left
    logic                dy_up_q, dy_up_d;     // 1: moving up
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [N_BLOCKS-1:0] blocks_q, blocks_d;
    logic                hit_q, hit_d;

    logic [9:0]          paddle_c;
    logic [10:0]         serve_sum;
    logic [10:0]         serve_raw;
    logic [9:0]          serve_x;
    logic [10:0]         centre;
    logic [10:0]         brick_idx;
    logic [N_BLOCKS-1:0] brick_sel;
    logic                brick_face;
    logic                brick_hit;
    logic                paddle_hit;
    logic                tick;
    logic [N_BLOCKS-1:0] blocks_left;

    // Clamp the paddle and derive the serve position in 11-bit arithmetic.
    always_comb begin
        paddle_c  = (paddle_x > P_MAX) ? P_MAX : paddle_x;
        serve_sum = {1'b0, paddle_c} + 11'(PADDLE_W / 2);
        if (serve_sum < 11'(BALL_SIZE / 2)) begin
            serve_raw = '0;
        end else begin
            serve_raw = serve_sum - 11'(BALL_SIZE / 2);
        end
        serve_x = (serve_raw > {1'b0, X_MAX}) ? X_MAX : serve_raw[9:0];
    end

    // Collision detection against the brick row and the paddle.
    always_comb begin
        centre     = {1'b0, x_q} + 11'(BALL_SIZE / 2);
        brick_idx  = centre >> IDX_SH;
        brick_sel  = '0;
        for (int unsigned i = 0; i < N_BLOCKS; i++) begin
            brick_sel[i] = (brick_idx == 11'(i));
        end
        brick_face = (dy_up_q && ({1'b0, y_q} == BRICK_BOT)) ||
                     (!dy_up_q && (({1'b0, y_q} + 11'(BALL_SIZE)) == BRICK_TOP));
        brick_hit  = brick_face && (|(brick_sel & blocks_q));
        paddle_hit = !dy_up_q &&
                     (({1'b0, y_q} + 11'(BALL_SIZE)) == PAD_TOP) &&
                     (({1'b0, x_q} + 11'(BALL_SIZE)) > {1'b0, paddle_c}) &&
                     ({1'b0, x_q} < ({1'b0, paddle_c} + 11'(PADDLE_W)));
        tick        = (cnt_q == CNT_LAST);
        blocks_left = blocks_q & ~brick_sel;
    end

    // Next-state, motion and brick bookkeeping.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        dx_neg_d = dx_neg_q;
        dy_up_d  = dy_up_q;
        cnt_d    = cnt_q;
        blocks_d = blocks_q;
        hit_d    = 1'b0;
        case (state_q)
            IDLE: begin
                x_d      = serve_x;
                y_d      = SERVE_Y;
                dx_neg_d = 1'b0;
                dy_up_d  = 1'b1;
                cnt_d    = '0;
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (tick) begin
                    cnt_d = '0;
                    // X axis: a reflection holds position for this tick
                    if (x_q == '0 && dx_neg_q) begin
                        dx_neg_d = 1'b0;
                    end else if (x_q == X_MAX && !dx_neg_q) begin
                        dx_neg_d = 1'b1;
                    end else begin
                        x_d = dx_neg_q ? (x_q - 10'd1) : (x_q + 10'd1);
                    end
                    // Y axis in priority order; a loss freezes both axes
                    if (!dy_up_q && y_q == Y_MAX) begin
                        state_d  = LOST;
                        x_d      = x_q;
                        dx_neg_d = dx_neg_q;
                    end else if (paddle_hit) begin
                        dy_up_d = 1'b1;
                    end else if (brick_hit) begin
                        blocks_d = blocks_left;
                        dy_up_d  = !dy_up_q;
                        hit_d    = 1'b1;
                        if (blocks_left == '0) begin
                            state_d = WIN;
                        end
                    end else if (dy_up_q && y_q == '0) begin
                        dy_up_d = 1'b0;
                    end else begin
                        y_d = dy_up_q ? (y_q - 10'd1) : (y_q + 10'd1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            LOST: begin
                if (!start) begin
                    state_d = IDLE;
                end
            end
            WIN: begin
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset to the serve position.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            x_q      <= serve_x;
            y_q      <= SERVE_Y;
            dx_neg_q <= 1'b0;
            dy_up_q  <= 1'b1;
            cnt_q    <= '0;
            blocks_q <= '1;
            hit_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            dx_neg_q <= dx_neg_d;
            dy_up_q  <= dy_up_d;
            cnt_q    <= cnt_d;
            blocks_q <= blocks_d;
            hit_q    <= hit_d;
        end
    end

    assign ball_x       = x_q;
    assign ball_y       = y_q;
    assign blocks_alive = blocks_q;
    assign hit_block    = hit_q;
    assign endgame_ball = (state_q == LOST);
    assign all_clear    = (state_q == WIN);
    assign moving       = (state_q == RUN);

endmodule

// File: tb/tb_ball_motion.sv
// Randomized bench for ball_motion: a full-size instance and a small-geometry
// instance both run against a behavioural game model.
module tb_ball_motion;

    typedef enum int {M_IDLE, M_RUN, M_LOST, M_WIN} mst_t;

    typedef struct packed {
        int hres; int vres; int bs; int py; int pw;
        int nb;   int bw;   int by; int bh; int sd;
    } geom_t;

    typedef struct packed {
        mst_t st;
        int   x; int y; int dx; int dy; int cnt;
        int   alive;
        bit   hit;
    } mdl_t;

    localparam int N_CYC = 40000;

    localparam geom_t GA = '{hres: 640, vres: 480, bs: 8, py: 440, pw: 64,
                             nb: 10, bw: 64, by: 32, bh: 16, sd: 2};
    localparam geom_t GB = '{hres: 64, vres: 48, bs: 4, py: 40, pw: 16,
                             nb: 4, bw: 16, by: 8, bh: 4, sd: 2};

    logic       clock = 1'b0;
    logic       reset;
    logic       start_a, start_b;
    logic [9:0] pad_a, pad_b;
    logic [9:0] a_x, a_y, b_x, b_y;
    logic [9:0] a_blocks;
    logic [3:0] b_blocks;
    logic       a_hit, a_end, a_clr, a_mov;
    logic       b_hit, b_end, b_clr, b_mov;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    mdl_t ma, mb;

    always #5 clock = ~clock;

    ball_motion #(
        .STEP_DIV(2)
    ) u_dut_a (
        .clock(clock), .reset(reset), .start(start_a), .paddle_x(pad_a),
        .ball_x(a_x), .ball_y(a_y), .blocks_alive(a_blocks),
        .hit_block(a_hit), .endgame_ball(a_end), .all_clear(a_clr),
        .moving(a_mov)
    );

    ball_motion #(
        .H_RES(64), .V_RES(48), .BALL_SIZE(4), .PADDLE_Y(40), .PADDLE_W(16),
        .N_BLOCKS(4), .BLOCK_W(16), .BLOCK_Y(8), .BLOCK_H(4), .STEP_DIV(2)
    ) u_dut_b (
        .clock(clock), .reset(reset), .start(start_b), .paddle_x(pad_b),
        .ball_x(b_x), .ball_y(b_y), .blocks_alive(b_blocks),
        .hit_block(b_hit), .endgame_ball(b_end), .all_clear(b_clr),
        .moving(b_mov)
    );

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s (cycle %0d): got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // One clock edge of the game, described directly from the rules.
    function automatic mdl_t step(input geom_t g, input mdl_t m, input bit rst,
                                  input bit st_in, input int pad);
        mdl_t n;
        int   pc, serve, idx;
        n     = m;
        n.hit = 1'b0;
        pc    = clampi(pad, 0, g.hres - g.pw);
        serve = clampi(pc + g.pw / 2 - g.bs / 2, 0, g.hres - g.bs);
        if (rst) begin
            n.st = M_IDLE; n.alive = (1 << g.nb) - 1;
            n.dx = 1; n.dy = -1; n.cnt = 0;
            n.x = serve; n.y = g.py - g.bs;
            return n;
        end
        case (m.st)
            M_IDLE: begin
                n.x = serve; n.y = g.py - g.bs; n.dx = 1; n.dy = -1; n.cnt = 0;
                if (st_in) n.st = M_RUN;
            end
            M_RUN: begin
                if (m.cnt != g.sd - 1) begin
                    n.cnt = m.cnt + 1;
                end else begin
                    n.cnt = 0;
                    idx = (m.x + g.bs / 2) / g.bw;
                    if (m.dy == 1 && m.y == g.vres - g.bs) begin
                        n.st = M_LOST;
                    end else begin
                        if ((m.x == 0 && m.dx == -1) || (m.x == g.hres - g.bs && m.dx == 1))
                            n.dx = -m.dx;
                        else
                            n.x = m.x + m.dx;
                        if (m.dy == 1 && m.y + g.bs == g.py && m.x + g.bs > pc && m.x < pc + g.pw) begin
                            n.dy = -1;
                        end else if (idx < g.nb && ((m.alive >> idx) & 1) != 0 &&
                                     ((m.dy == -1 && m.y == g.by + g.bh) ||
                                      (m.dy == 1 && m.y + g.bs == g.by))) begin
                            n.alive = m.alive & ~(1 << idx);
                            n.dy    = -m.dy;
                            n.hit   = 1'b1;
                            if (n.alive == 0) n.st = M_WIN;
                        end else if (m.dy == -1 && m.y == 0) begin
                            n.dy = 1;
                        end else begin
                            n.y = m.y + m.dy;
                        end
                    end
                end
            end
            M_LOST: if (!st_in) n.st = M_IDLE;
            default: ;
        endcase
        return n;
    endfunction

    // Player behaviour: serve at random spots, mostly keep the paddle under the ball.
    task automatic pick(input geom_t g, input mdl_t m, inout int hold, inout bit follow,
                        output bit st, output int pad);
        case (m.st)
            M_IDLE: begin
                follow = ($urandom_range(0, 9) != 0);
                hold   = $urandom_range(1, 60);
                st     = ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 7) == 0) pad = $urandom_range(0, 1023);
                else pad = $urandom_range(0, g.hres - g.pw);
            end
            M_RUN: begin
                st = $urandom_range(0, 1);
                if (follow)
                    pad = clampi(m.x + g.bs / 2 - g.pw / 2 +
                                 $urandom_range(0, g.pw - 2) - (g.pw / 2 - 1),
                                 0, g.hres - g.pw);
                else
                    pad = (m.x < g.hres / 2) ? g.hres - g.pw : 0;
            end
            M_LOST: begin
                if (hold > 0) begin
                    hold--;
                    st = 1'b1;
                end else begin
                    st = 1'b0;
                end
                pad = $urandom_range(0, g.hres - g.pw);
            end
            default: begin
                st  = $urandom_range(0, 1);
                pad = $urandom_range(0, g.hres - g.pw);
            end
        endcase
    endtask

    task automatic compare_all();
        check("A.ball_x", int'(a_x), ma.x);
        check("A.ball_y", int'(a_y), ma.y);
        check("A.blocks", int'(a_blocks), ma.alive);
        check("A.hit", int'(a_hit), int'(ma.hit));
        check("A.endgame", int'(a_end), (ma.st == M_LOST) ? 1 : 0);
        check("A.all_clear", int'(a_clr), (ma.st == M_WIN) ? 1 : 0);
        check("A.moving", int'(a_mov), (ma.st == M_RUN) ? 1 : 0);
        check("B.ball_x", int'(b_x), mb.x);
        check("B.ball_y", int'(b_y), mb.y);
        check("B.blocks", int'(b_blocks), mb.alive);
        check("B.hit", int'(b_hit), int'(mb.hit));
        check("B.endgame", int'(b_end), (mb.st == M_LOST) ? 1 : 0);
        check("B.all_clear", int'(b_clr), (mb.st == M_WIN) ? 1 : 0);
        check("B.moving", int'(b_mov), (mb.st == M_RUN) ? 1 : 0);
    endtask

    task automatic edge_and_compare();
        @(posedge clock);
        ma = step(GA, ma, reset, start_a, int'(pad_a));
        mb = step(GB, mb, reset, start_b, int'(pad_b));
        cyc++;
        @(negedge clock);
        compare_all();
    endtask

    initial begin
        int   hold_a = 0, hold_b = 0;
        bit   fol_a = 1'b1, fol_b = 1'b1;
        bit   sa, sb, rst_now, rst_done;
        int   pa, pb, a_hits;
        mdl_t la;

        ma = '0; mb = '0;
        rst_done = 1'b0; a_hits = 0;
        reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
        pad_a = 10'd288; pad_b = 10'd20;
        edge_and_compare();
        edge_and_compare();
        check("rst.ball_x", int'(a_x), 316);
        check("rst.ball_y", int'(a_y), 432);
        check("rst.blocks", int'(a_blocks), 'h3FF);
        check("rst.status", int'({a_hit, a_end, a_clr, a_mov}), 0);

        reset = 1'b0; pad_a = 10'd100;
        edge_and_compare();
        check("idle.track", int'(a_x), 128);

        for (int i = 0; i < N_CYC; i++) begin
            pick(GA, ma, hold_a, fol_a, sa, pa);
            pick(GB, mb, hold_b, fol_b, sb, pb);
            start_a = sa; pad_a = pa[9:0];
            start_b = sb; pad_b = pb[9:0];
            rst_now = 1'b0;
            if (!rst_done && a_hits >= 1) begin
                la = step(GA, ma, 1'b0, sa, pa);
                if (la.hit) rst_now = 1'b1;
            end
            reset = rst_now;
            edge_and_compare();
            if (ma.hit) a_hits++;
            if (rst_now) begin
                rst_done = 1'b1;
                check("rsthit.hit", int'(a_hit), 0);
                check("rsthit.blocks", int'(a_blocks), 'h3FF);
                check("rsthit.moving", int'(a_mov), 0);
            end
        end
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
